safety_cl_periph_bridge: RTL and testbench
==========================================

# safety_cl_periph_bridge

Responder for the safety core's data memory interface (req/gnt/rvalid handshake) and initiator on the core-local peripheral register bus (`reg_req_t`/`reg_rsp_t`). Accepts one data access at a time, range-checks it against the core-local peripheral window, and performs a single register-bus transfer. Returns read data or error to the core. Sits between the core data-port crossbar and the core-local peripheral port (CLIC, timer, TCLS).

## Interface
Parameters:
- `PeriphBaseAddr`, 32'h0020_0000, base of the core-local peripheral window.
- `PeriphAddrRange`, 32'h0001_0000, window size in bytes; the window is [base, base+range).
- `TimeoutCycles`, 256, register-bus wait limit; ≥2; used only with the timeout feature.
- `reg_req_t`, logic, register-bus request type (addr, write, wdata, wstrb, valid).
- `reg_rsp_t`, logic, register-bus response type (rdata, error, ready).

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `data_req_i` in 1: core request.
- `data_gnt_o` out 1: request accepted.
- `data_we_i` in 1: write enable.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_rvalid_o` out 1: response valid, one-cycle pulse.
- `data_rdata_o` out 32: read data.
- `data_err_o` out 1: response error.
- `cl_periph_req_o` out reg_req_t: register-bus request.
- `cl_periph_rsp_i` in reg_rsp_t: register-bus response.
- `busy_o` out 1: asserted in any state other than IDLE.

## Operation
- FSM states are IDLE, REG and RESP.
- IDLE: `data_gnt_o = 1`, combinational. When `data_req_i` is high:
  - Latch addr, we, be and wdata.
  - If the address is in the window, go to REG.
  - Otherwise, latch err=1 and rdata=32'hBADCAB1E, then go to RESP. No bus access is made.
- REG: drive `cl_periph_req_o` from the latched fields: valid=1, write=we, wstrb=be, addr unchanged.
  - On `ready`, capture rsp.rdata and rsp.error, drop valid, go to RESP.
  - Writes return rdata='0.
- RESP: `data_rvalid_o = 1` with the latched rdata/err for exactly one cycle, then IDLE.
- `data_gnt_o = 0` in REG and RESP. At most one transaction is outstanding.
- Request fields in REG are stable and come only from registers, so input changes after grant are ignored.
- Range check is unsigned: `addr >= base && addr - base < range`. Subtraction is 32-bit. Base+range must not wrap past 2^32 (static parameter assertion).
- `rsp.error` with `ready` gives `data_err_o = 1` and rdata as returned by the slave.
- Reset in any state:
  - Immediate (asynchronous) return to IDLE.
  - `cl_periph_req_o.valid` drops at once and the in-flight access is discarded with no response.
  - All latched fields clear to 0.
- Output reset values: `data_gnt_o = 1` (IDLE); `data_rvalid_o`, `data_err_o`, `busy_o` = 0; `data_rdata_o`, `cl_periph_req_o` = '0.

## Timing
- Grant is in cycle N.
- REG valid is driven in N+1.
- If `ready` arrives in N+1, `rvalid` is in N+2. Best-case in-window latency is 2 cycles from grant to rvalid.
- Out-of-window access: `rvalid` in N+1.
- Each wait cycle on `ready` adds one cycle.
- Next grant is possible in the cycle after `rvalid`. Throughput is one access per 3 cycles.
- `ready` asserted while not in REG is ignored.

## Configuration
- Macro `SAFETY_CL_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to REG and increments each REG cycle without `ready`.
  - When it reaches `TimeoutCycles` without `ready`, drop valid, go to RESP with err=1 and rdata=32'hBADCAB1E.
  - `ready` in the same cycle as the limit wins: normal response.
  - Counter width is `$clog2(TimeoutCycles+1)`.
- Undefined: no counter. REG waits indefinitely.

## Structure
- `safety_island_pkg` gains:
  - `ClPeriphBridgeErrVal` = 32'hBADCAB1E.
  - The default window constants, which reuse the existing peripheral base/offset constants.
- FSM state enum stays local to the module.
- No sub-module. The timeout counter is inline under the macro guard.

## Test plan
- In-window read 0x0020_0010, slave `ready` same cycle with rdata 0xCAFE0001 → rvalid 2 cycles after gnt, rdata 0xCAFE0001, err 0; exactly one valid cycle on the bus.
- In-window write 0x0020_0004, be 4'b0011, wdata 0x1234_5678, slave waits 5 cycles → bus wstrb 0011, write=1, fields stable for all 6 valid cycles; rvalid at grant+7, err 0, rdata 0.
- Read 0x0030_0000 (out of window) → no bus valid; rvalid at grant+1, err 1, rdata 0xBADCAB1E. Also check the boundary 0x0020_FFFC (in window) versus 0x0021_0000 (out).
- Slave returns error=1 → err 1; no new grant until after rvalid; back-to-back requests serviced in order.
- rst_ni low while in REG → valid falls asynchronously, no rvalid, gnt=1 after release.
- With `SAFETY_CL_BRIDGE_TIMEOUT_EN`, TimeoutCycles=8, slave never ready → valid high 8 cycles, then err 1, rdata 0xBADCAB1E. Ready on the 8th cycle → normal response.

Source files
------------

// File: rtl/safety_island_pkg.sv
// Shared safety-island constants and register-bus types.
// Used by safety_cl_periph_bridge (optional timeout via SAFETY_CL_BRIDGE_TIMEOUT_EN).
package safety_island_pkg;

  localparam logic [31:0] SafetyIslandPeriphBase = 32'h0020_0000;
  localparam logic [31:0] ClPeriphOffset         = 32'h0000_0000;
  localparam logic [31:0] ClPeriphSize           = 32'h0001_0000;

  localparam logic [31:0] ClPeriphBridgeBase   = SafetyIslandPeriphBase + ClPeriphOffset;
  localparam logic [31:0] ClPeriphBridgeRange  = ClPeriphSize;
  localparam logic [31:0] ClPeriphBridgeErrVal = 32'hBADCAB1E;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } safety_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } safety_reg_rsp_t;

  // Unsigned window test; the subtraction wraps for addresses below base.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] range);
    return (addr >= base) && ((addr - base) < range);
  endfunction

endpackage

// File: rtl/safety_cl_periph_bridge.sv
// Core data-port responder bridging one access at a time onto the core-local register bus.
// Define SAFETY_CL_BRIDGE_TIMEOUT_EN to bound the register-bus wait to TimeoutCycles.
module safety_cl_periph_bridge
  import safety_island_pkg::*;
#(
  parameter logic [31:0] PeriphBaseAddr  = ClPeriphBridgeBase,
  parameter logic [31:0] PeriphAddrRange = ClPeriphBridgeRange,
  parameter int unsigned TimeoutCycles   = 256,
  parameter type         reg_req_t       = safety_reg_req_t,
  parameter type         reg_rsp_t       = safety_reg_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output reg_req_t    cl_periph_req_o,
  input  reg_rsp_t    cl_periph_rsp_i,
  output logic        busy_o
);

  localparam logic [32:0] WindowEnd = {1'b0, PeriphBaseAddr} + {1'b0, PeriphAddrRange};

  if (WindowEnd > 33'h1_0000_0000) begin : g_window_wraps
    $error("peripheral window wraps past 2^32");
  end
  if (TimeoutCycles < 2) begin : g_timeout_too_small
    $error("TimeoutCycles must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, REG, RESP} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_in_window;
  logic        w_timeout;

  assign w_in_window = addr_in_window(data_addr_i, PeriphBaseAddr, PeriphAddrRange);

`ifdef SAFETY_CL_BRIDGE_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_cnt;

  // Fires on the last allowed wait cycle; a coincident ready still takes priority.
  assign w_timeout = (r_cnt == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state != REG) begin
      r_cnt <= '0;
    end else if (!cl_periph_rsp_i.ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    data_gnt_o      = 1'b0;
    data_rvalid_o   = 1'b0;
    data_rdata_o    = '0;
    data_err_o      = 1'b0;
    busy_o          = 1'b1;
    cl_periph_req_o = '0;
    case (r_state)
      IDLE: begin
        data_gnt_o = 1'b1;
        busy_o     = 1'b0;
        if (data_req_i) begin
          w_state_next = w_in_window ? REG : RESP;
        end
      end
      REG: begin
        cl_periph_req_o.valid = 1'b1;
        cl_periph_req_o.addr  = r_addr;
        cl_periph_req_o.write = r_we;
        cl_periph_req_o.wstrb = r_be;
        cl_periph_req_o.wdata = r_wdata;
        if (cl_periph_rsp_i.ready || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = r_rdata;
        data_err_o    = r_err;
        w_state_next  = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (data_req_i) begin
            r_addr  <= data_addr_i;
            r_we    <= data_we_i;
            r_be    <= data_be_i;
            r_wdata <= data_wdata_i;
            r_err   <= !w_in_window;
            r_rdata <= w_in_window ? 32'h0 : ClPeriphBridgeErrVal;
          end
        end
        REG: begin
          if (cl_periph_rsp_i.ready) begin
            r_rdata <= r_we ? 32'h0 : cl_periph_rsp_i.rdata;
            r_err   <= cl_periph_rsp_i.error;
          end else if (w_timeout) begin
            r_rdata <= ClPeriphBridgeErrVal;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_safety_cl_periph_bridge.sv
// Scoreboard bench for safety_cl_periph_bridge with a cycle-accurate register-bus slave.
module tb_safety_cl_periph_bridge;
  import safety_island_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            data_req = 1'b0;
  logic            data_gnt;
  logic            data_we = 1'b0;
  logic [3:0]      data_be = '0;
  logic [31:0]     data_addr = '0;
  logic [31:0]     data_wdata = '0;
  logic            data_rvalid;
  logic [31:0]     data_rdata;
  logic            data_err;
  safety_reg_req_t bus_req;
  safety_reg_rsp_t bus_rsp = '0;
  logic            busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  safety_cl_periph_bridge #(
    .PeriphBaseAddr (32'h0020_0000),
    .PeriphAddrRange(32'h0001_0000),
    .TimeoutCycles  (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .cl_periph_req_o(bus_req),
    .cl_periph_rsp_i(bus_rsp),
    .busy_o         (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outside REG the slave deliberately asserts a bogus ready, which must be ignored.
  task automatic idle_slave();
    bus_rsp.ready = 1'b1;
    bus_rsp.error = 1'b1;
    bus_rsp.rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input int wait_c,
                        input logic [31:0] slv_rdata, input logic slv_err,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_vcnt, input int exp_lat);
    int   vcnt;
    logic done;
    logic fields_ok;
    exp_t e;
    vcnt = 0;
    done = 1'b0;
    @(negedge clk);
    check_val({tag, "_gnt_idle"}, 64'(data_gnt), 64'd1);
    check_val({tag, "_busy_idle"}, 64'(busy), 64'd0);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
    idle_slave();
    sb_q.push_back('{exp_rdata, exp_err});
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        data_we    = ~we;
        data_be    = ~be;
        data_addr  = ~addr;
        data_wdata = ~wdata;
      end
      check_val({tag, "_gnt_busy"}, {62'd0, data_gnt, busy}, 64'd1);
      if (bus_req.valid) begin
        vcnt++;
        fields_ok = (bus_req.addr == addr) && (bus_req.write == we) &&
                    (bus_req.wstrb == be) && (bus_req.wdata == wdata);
        check_val({tag, "_bus_fields"}, 64'(fields_ok), 64'd1);
        bus_rsp.ready = (vcnt == wait_c + 1);
        bus_rsp.error = slv_err;
        bus_rsp.rdata = slv_rdata;
      end else begin
        idle_slave();
      end
      if (data_rvalid) begin
        done = 1'b1;
        check_val({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check_val({tag, "_valid_cycles"}, 64'(vcnt), 64'(exp_vcnt));
        if (sb_q.size() == 0) begin
          check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val({tag, "_rdata"}, 64'(data_rdata), 64'(e.rdata));
          check_val({tag, "_err"}, 64'(data_err), 64'(e.err));
        end
        $display("[TB] txn %s we=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d bus_cycles=%0d",
                 tag, we, addr, data_rdata, data_err, k, vcnt);
      end
    end
    if (!done) check_val({tag, "_rvalid_seen"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic        rw_we;
    logic        in_win;
    logic [31:0] raddr;
    logic [31:0] rdat;
    int          rwait;

    idle_slave();
    @(negedge clk);
    check_val("rst_gnt", 64'(data_gnt), 64'd1);
    check_val("rst_rvalid", 64'(data_rvalid), 64'd0);
    check_val("rst_err", 64'(data_err), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rdata", 64'(data_rdata), 64'd0);
    check_val("rst_bus_valid", 64'(bus_req.valid), 64'd0);
    check_val("rst_bus_addr", 64'(bus_req.addr), 64'd0);
    rst_n = 1'b1;

    do_txn("rd_win", 1'b0, 4'hF, 32'h0020_0010, 32'h0, 0, 32'hCAFE_0001, 1'b0,
           32'hCAFE_0001, 1'b0, 1, 2);
    do_txn("wr_wait5", 1'b1, 4'b0011, 32'h0020_0004, 32'h1234_5678, 5, 32'h5555_AAAA, 1'b0,
           32'h0, 1'b0, 6, 7);
    do_txn("rd_out", 1'b0, 4'hF, 32'h0030_0000, 32'h0, 0, 32'h1111_1111, 1'b0,
           32'hBADC_AB1E, 1'b1, 0, 1);
    do_txn("rd_top", 1'b0, 4'hF, 32'h0020_FFFC, 32'h0, 2, 32'h1357_2468, 1'b0,
           32'h1357_2468, 1'b0, 3, 4);
    do_txn("rd_end", 1'b0, 4'hF, 32'h0021_0000, 32'h0, 0, 32'h2222_2222, 1'b0,
           32'hBADC_AB1E, 1'b1, 0, 1);
    do_txn("rd_below", 1'b0, 4'hF, 32'h001F_FFFC, 32'h0, 0, 32'h3333_3333, 1'b0,
           32'hBADC_AB1E, 1'b1, 0, 1);
    do_txn("rd_slverr", 1'b0, 4'hF, 32'h0020_0100, 32'h0, 1, 32'h0BAD_0001, 1'b1,
           32'h0BAD_0001, 1'b1, 2, 3);
    do_txn("wr_slverr", 1'b1, 4'b1100, 32'h0020_0200, 32'hA5A5_5A5A, 0, 32'h4444_4444, 1'b1,
           32'h0, 1'b1, 1, 2);

    for (int i = 0; i < 8; i++) begin
      rw_we  = 1'($urandom_range(0, 1));
      in_win = 1'($urandom_range(0, 3) != 0);
      raddr  = in_win ? (32'h0020_0000 | ($urandom() & 32'h0000_FFFC)) : (32'h0040_0000 + 32'(i * 4));
      rdat   = $urandom();
      rwait  = $urandom_range(0, 3);
      if (in_win)
        do_txn($sformatf("b2b_%0d", i), rw_we, 4'(i), raddr, $urandom(), rwait, rdat, 1'b0,
               rw_we ? 32'h0 : rdat, 1'b0, rwait + 1, rwait + 2);
      else
        do_txn($sformatf("b2b_%0d", i), rw_we, 4'(i), raddr, $urandom(), rwait, rdat, 1'b0,
               32'hBADC_AB1E, 1'b1, 0, 1);
    end

    // Abort an access mid-wait: valid must drop without a clock edge and no response follows.
    @(negedge clk);
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h0020_0020;
    @(negedge clk);
    data_req      = 1'b0;
    bus_rsp.ready = 1'b0;
    check_val("rstmid_valid_before", 64'(bus_req.valid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_valid_async", 64'(bus_req.valid), 64'd0);
    check_val("rstmid_gnt", 64'(data_gnt), 64'd1);
    check_val("rstmid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_slave();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rstmid_no_rvalid", 64'(data_rvalid), 64'd0);
      check_val("rstmid_gnt_after", 64'(data_gnt), 64'd1);
    end
    $display("[TB] txn rst_in_reg aborted");

`ifdef SAFETY_CL_BRIDGE_TIMEOUT_EN
    do_txn("to_never", 1'b0, 4'hF, 32'h0020_0030, 32'h0, 1000, 32'h6666_6666, 1'b0,
           32'hBADC_AB1E, 1'b1, 8, 9);
    do_txn("to_ready8", 1'b0, 4'hF, 32'h0020_0034, 32'h0, 7, 32'h7777_0008, 1'b0,
           32'h7777_0008, 1'b0, 8, 9);
`endif

    do_txn("rd_final", 1'b0, 4'hF, 32'h0020_0040, 32'h0, 0, 32'h8888_0001, 1'b0,
           32'h8888_0001, 1'b0, 1, 2);
    data_req = 1'b0;
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
